// File: rtl/sram_rmw_arbiter.sv
// Arbitrates one single-port weight SRAM between an inference read port (R) and a
// read-modify-write learning update port (U) with a starvation bound on U.
module sram_rmw_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SRAM_DEPTH   = 256,
    parameter int unsigned DELTA_WIDTH  = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                   CK,
    input  logic                   RSTN,
    input  logic                   rd_req,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic                   rd_gnt,
    output logic                   rd_valid,
    output logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   upd_req,
    input  logic [ADDR_WIDTH-1:0]  upd_addr,
    input  logic [DELTA_WIDTH-1:0] upd_delta,
    output logic                   upd_gnt,
    output logic                   upd_done,
    output logic                   busy,
    output logic                   sram_cs,
    output logic                   sram_we,
    output logic [ADDR_WIDTH-1:0]  sram_a,
    output logic [DATA_WIDTH-1:0]  sram_d,
    input  logic [DATA_WIDTH-1:0]  sram_q
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

    if (SRAM_DEPTH > (1 << ADDR_WIDTH) || DELTA_WIDTH > DATA_WIDTH || STARVE_LIMIT < 1)
    begin : g_param_check
        $error("sram_rmw_arbiter: illegal parameter combination");
    end

    typedef enum logic [0:0] {StIdle, StWr} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        starve_cnt_q;
    logic                   rd_valid_q, upd_done_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DELTA_WIDTH-1:0] delta_q;
    logic [DATA_WIDTH:0]    sum_wide;
    logic [DATA_WIDTH-1:0]  sat_sum;
    logic                   u_win;

    // One extra bit of headroom; overflow shows up as disagreement of the top two bits.
    always_comb begin
        sum_wide = {sram_q[DATA_WIDTH-1], sram_q}
                 + {{(DATA_WIDTH + 1 - DELTA_WIDTH){delta_q[DELTA_WIDTH-1]}}, delta_q};
        sat_sum  = sum_wide[DATA_WIDTH-1:0];
        if (sum_wide[DATA_WIDTH] != sum_wide[DATA_WIDTH-1]) begin
            sat_sum = sum_wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        state_d = state_q;
        rd_gnt  = 1'b0;
        upd_gnt = 1'b0;
        sram_cs = 1'b0;
        sram_we = 1'b0;
        sram_a  = '0;
        sram_d  = '0;
        u_win   = upd_req & (~rd_req | (starve_cnt_q == StarveMax));
        // Gating on RSTN keeps every control output low (and aborts a pending write) in reset.
        if (RSTN) begin
            unique case (state_q)
                StIdle: begin
                    if (u_win) begin
                        upd_gnt = 1'b1;
                        sram_cs = 1'b1;
                        sram_a  = upd_addr;
                        state_d = StWr;
                    end else if (rd_req) begin
                        rd_gnt  = 1'b1;
                        sram_cs = 1'b1;
                        sram_a  = rd_addr;
                    end
                end
                StWr: begin
                    sram_cs = 1'b1;
                    sram_we = 1'b1;
                    sram_a  = addr_q;
                    sram_d  = sat_sum;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
            rd_valid_q   <= 1'b0;
            upd_done_q   <= 1'b0;
            addr_q       <= '0;
            delta_q      <= '0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_gnt;
            upd_done_q <= (state_q == StWr);
            if (upd_gnt) begin
                addr_q  <= upd_addr;
                delta_q <= upd_delta;
            end
            if (upd_gnt) begin
                starve_cnt_q <= '0;
            end else if (upd_req && starve_cnt_q != StarveMax) begin
                starve_cnt_q <= starve_cnt_q + CntW'(1);
            end
        end
    end

    assign busy     = RSTN & (state_q == StWr);
    assign rd_valid = RSTN & rd_valid_q;
    assign upd_done = RSTN & upd_done_q;
    assign rd_data  = sram_q;

endmodule

// File: tb/tb_sram_rmw_arbiter.sv
// Directed bench for sram_rmw_arbiter with a behavioural single-port SRAM
// (registered Q, held while CS=0, old-data-on-write).
module tb_sram_rmw_arbiter;

    localparam int SRAM_DEPTH = 256;

    logic        CK = 1'b0;
    logic        RSTN;
    logic        rd_req, upd_req;
    logic [7:0]  rd_addr, upd_addr, upd_delta;
    logic        rd_gnt, rd_valid, upd_gnt, upd_done, busy;
    logic [31:0] rd_data;
    logic        sram_cs, sram_we;
    logic [7:0]  sram_a;
    logic [31:0] sram_d;
    logic [31:0] sram_q = 32'h0;
    logic [31:0] mem [SRAM_DEPTH];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CK = ~CK;

    sram_rmw_arbiter #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (32),
        .SRAM_DEPTH  (SRAM_DEPTH),
        .DELTA_WIDTH (8),
        .STARVE_LIMIT(4)
    ) dut (
        .CK       (CK),
        .RSTN     (RSTN),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_gnt   (rd_gnt),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .upd_req  (upd_req),
        .upd_addr (upd_addr),
        .upd_delta(upd_delta),
        .upd_gnt  (upd_gnt),
        .upd_done (upd_done),
        .busy     (busy),
        .sram_cs  (sram_cs),
        .sram_we  (sram_we),
        .sram_a   (sram_a),
        .sram_d   (sram_d),
        .sram_q   (sram_q)
    );

    always @(posedge CK) begin
        if (sram_cs) begin
            if (int'(sram_a) >= SRAM_DEPTH) $error("illegal SRAM address %0d", sram_a);
            sram_q <= mem[sram_a];
            if (sram_we) mem[sram_a] <= sram_d;
        end
    end

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    task automatic test_reset;
        RSTN = 1'b0; rd_req = 1'b1; rd_addr = 8'h10; upd_req = 1'b1; upd_addr = 8'h20;
        upd_delta = 8'h01;
        tick; tick;
        #2;
        n_cmp++;
        if ({rd_gnt, upd_gnt, sram_cs, sram_we, rd_valid, upd_done, busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {rd_gnt, upd_gnt, sram_cs, sram_we, rd_valid, upd_done, busy});
        end
        n_cmp++;
        if ({sram_a, sram_d} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_addr_data: got a=%h d=%h expected 0/0", sram_a, sram_d);
        end
        tick;
        RSTN = 1'b1; rd_req = 1'b0; upd_req = 1'b0;
    endtask

    task automatic test_single_read;
        tick;
        rd_req = 1'b1; rd_addr = 8'h10;
        #2;
        n_cmp++;
        if ({rd_gnt, upd_gnt, sram_cs, sram_we, sram_a} !== {4'b1010, 8'h10}) begin
            n_fail++;
            $display("FAIL read_gnt: got gnt=%b ugnt=%b cs=%b we=%b a=%h expected 1 0 1 0 10",
                     rd_gnt, upd_gnt, sram_cs, sram_we, sram_a);
        end
        tick;
        rd_req = 1'b0;
        #2;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0000_0123) begin
            n_fail++;
            $display("FAIL read_data: got valid=%b data=%h expected 1 00000123", rd_valid, rd_data);
        end
        tick;
        #2;
        n_cmp++;
        if (rd_valid !== 1'b0 || sram_cs !== 1'b0) begin
            n_fail++;
            $display("FAIL read_idle: got valid=%b cs=%b expected 0 0", rd_valid, sram_cs);
        end
    endtask

    task automatic test_single_rmw;
        tick;
        upd_req = 1'b1; upd_addr = 8'h20; upd_delta = 8'hFD;
        #2;
        n_cmp++;
        if ({upd_gnt, rd_gnt, sram_cs, sram_we, sram_a} !== {4'b1010, 8'h20}) begin
            n_fail++;
            $display("FAIL rmw_gnt: got ugnt=%b rgnt=%b cs=%b we=%b a=%h expected 1 0 1 0 20",
                     upd_gnt, rd_gnt, sram_cs, sram_we, sram_a);
        end
        tick;
        upd_req = 1'b0; upd_addr = 8'hEE; upd_delta = 8'h55;
        #2;
        n_cmp++;
        if ({busy, sram_cs, sram_we, sram_a, sram_d} !== {3'b111, 8'h20, 32'd97}) begin
            n_fail++;
            $display("FAIL rmw_write: got busy=%b cs=%b we=%b a=%h d=%0d expected 1 1 1 20 97",
                     busy, sram_cs, sram_we, sram_a, sram_d);
        end
        tick;
        #2;
        n_cmp++;
        if ({upd_done, busy} !== 2'b10 || rd_data !== 32'd100) begin
            n_fail++;
            $display("FAIL rmw_done: got done=%b busy=%b rd_data=%0d expected 1 0 100",
                     upd_done, busy, rd_data);
        end
        rd_req = 1'b1; rd_addr = 8'h20;
        tick;
        rd_req = 1'b0;
        #2;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd97 || upd_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rmw_readback: got valid=%b data=%0d done=%b expected 1 97 0",
                     rd_valid, rd_data, upd_done);
        end
    endtask

    task automatic test_saturation;
        logic [7:0]  addr [4];
        logic [31:0] init [4];
        logic [7:0]  dlt  [4];
        logic [31:0] expv [4];
        addr = '{8'h30, 8'h31, 8'h32, 8'h33};
        init = '{32'h7FFF_FFF0, 32'h8000_0005, 32'h0000_0010, 32'hFFFF_FFFE};
        dlt  = '{8'h7F, 8'h80, 8'h00, 8'h05};
        expv = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0010, 32'h0000_0003};
        for (int i = 0; i < 4; i++) begin
            mem[addr[i]] = init[i];
            tick;
            upd_req = 1'b1; upd_addr = addr[i]; upd_delta = dlt[i];
            tick;
            upd_req = 1'b0;
            #2;
            n_cmp++;
            if (sram_we !== 1'b1 || sram_a !== addr[i] || sram_d !== expv[i]) begin
                n_fail++;
                $display("FAIL sat_write[%0d]: got we=%b a=%h d=%h expected 1 %h %h",
                         i, sram_we, sram_a, sram_d, addr[i], expv[i]);
            end
            tick;
            #2;
            n_cmp++;
            if (upd_done !== 1'b1 || mem[addr[i]] !== expv[i]) begin
                n_fail++;
                $display("FAIL sat_stored[%0d]: got done=%b mem=%h expected 1 %h",
                         i, upd_done, mem[addr[i]], expv[i]);
            end
        end
    endtask

    task automatic test_starvation;
        mem[8'h60] = 32'h0000_0011;
        mem[8'h61] = 32'hAAAA_0061;
        tick;
        rd_req = 1'b1; rd_addr = 8'h61;
        upd_req = 1'b1; upd_addr = 8'h60; upd_delta = 8'h01;
        for (int i = 0; i < 4; i++) begin
            #2;
            n_cmp++;
            if ({rd_gnt, upd_gnt} !== 2'b10) begin
                n_fail++;
                $display("FAIL starve_denied[%0d]: got rgnt=%b ugnt=%b expected 1 0",
                         i, rd_gnt, upd_gnt);
            end
            tick;
        end
        #2;
        n_cmp++;
        if ({rd_gnt, upd_gnt, sram_a} !== {2'b01, 8'h60}) begin
            n_fail++;
            $display("FAIL starve_override: got rgnt=%b ugnt=%b a=%h expected 0 1 60",
                     rd_gnt, upd_gnt, sram_a);
        end
        tick;
        upd_req = 1'b0;
        #2;
        n_cmp++;
        if ({rd_gnt, busy, sram_we, rd_valid} !== 4'b0110 || sram_d !== 32'h12) begin
            n_fail++;
            $display("FAIL starve_wr: got rgnt=%b busy=%b we=%b valid=%b d=%h expected 0 1 1 0 12",
                     rd_gnt, busy, sram_we, rd_valid, sram_d);
        end
        tick;
        #2;
        n_cmp++;
        if ({rd_gnt, upd_done, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL starve_resume: got rgnt=%b done=%b busy=%b expected 1 1 0",
                     rd_gnt, upd_done, busy);
        end
        tick;
        rd_req = 1'b0;
        #2;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hAAAA_0061) begin
            n_fail++;
            $display("FAIL starve_read: got valid=%b data=%h expected 1 aaaa0061", rd_valid, rd_data);
        end
    endtask

    task automatic test_read_after_update;
        mem[8'h40] = 32'd5;
        tick;
        upd_req = 1'b1; upd_addr = 8'h40; upd_delta = 8'h02;
        #2;
        n_cmp++;
        if (upd_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rau_ugnt: got %b expected 1", upd_gnt);
        end
        tick;
        upd_req = 1'b0; rd_req = 1'b1; rd_addr = 8'h40;
        #2;
        n_cmp++;
        if ({rd_gnt, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL rau_blocked: got rgnt=%b busy=%b expected 0 1", rd_gnt, busy);
        end
        tick;
        #2;
        n_cmp++;
        if ({rd_gnt, upd_done} !== 2'b11 || rd_data !== 32'd5) begin
            n_fail++;
            $display("FAIL rau_gnt: got rgnt=%b done=%b rd_data=%0d expected 1 1 5",
                     rd_gnt, upd_done, rd_data);
        end
        tick;
        rd_req = 1'b0;
        #2;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd7) begin
            n_fail++;
            $display("FAIL rau_data: got valid=%b data=%0d expected 1 7", rd_valid, rd_data);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  addr [3];
        logic [31:0] expv [3];
        addr = '{8'h10, 8'h20, 8'h30};
        expv = '{32'h0000_0123, 32'd97, 32'h7FFF_FFFF};
        tick;
        for (int i = 0; i < 4; i++) begin
            rd_req = (i < 3);
            rd_addr = (i < 3) ? addr[i] : 8'h00;
            #2;
            if (i < 3) begin
                n_cmp++;
                if (rd_gnt !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_gnt[%0d]: got %b expected 1", i, rd_gnt);
                end
            end
            if (i > 0) begin
                n_cmp++;
                if (rd_valid !== 1'b1 || rd_data !== expv[i-1]) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got valid=%b data=%h expected 1 %h",
                             i - 1, rd_valid, rd_data, expv[i-1]);
                end
            end
            tick;
        end
    endtask

    task automatic test_reset_mid_rmw;
        mem[8'h50] = 32'd9;
        tick;
        upd_req = 1'b1; upd_addr = 8'h50; upd_delta = 8'h01;
        #2;
        n_cmp++;
        if (upd_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_rmw_ugnt: got %b expected 1", upd_gnt);
        end
        tick;
        upd_req = 1'b0; RSTN = 1'b0;
        #2;
        n_cmp++;
        if ({sram_cs, sram_we, busy, upd_gnt, rd_gnt, rd_valid, upd_done} !== 7'b0) begin
            n_fail++;
            $display("FAIL rst_rmw_wr: got %b expected 0000000",
                     {sram_cs, sram_we, busy, upd_gnt, rd_gnt, rd_valid, upd_done});
        end
        tick;
        #2;
        n_cmp++;
        if ({upd_done, rd_valid, busy, sram_cs} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_rmw_hold: got %b expected 0000", {upd_done, rd_valid, busy, sram_cs});
        end
        tick;
        RSTN = 1'b1;
        #2;
        n_cmp++;
        if (upd_done !== 1'b0 || mem[8'h50] !== 32'd9) begin
            n_fail++;
            $display("FAIL rst_rmw_abort: got done=%b mem=%0d expected 0 9", upd_done, mem[8'h50]);
        end
        rd_req = 1'b1; rd_addr = 8'h50;
        tick;
        rd_req = 1'b0;
        #2;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd9) begin
            n_fail++;
            $display("FAIL rst_rmw_read: got valid=%b data=%0d expected 1 9", rd_valid, rd_data);
        end
    endtask

    initial begin
        for (int i = 0; i < SRAM_DEPTH; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'h0000_0123;
        mem[8'h20] = 32'd100;
        test_reset;
        test_single_read;
        test_single_rmw;
        test_saturation;
        test_starvation;
        test_read_after_update;
        test_back_to_back;
        test_reset_mid_rmw;
        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_rmw_arbiter.md
Name: sram_rmw_arbiter

Overview:
- Sits in front of one single-port weight SRAM: 1-cycle synchronous read, registered Q held while CS=0, old-data-on-write.
- Shares the SRAM between two requesters: the inference read port (R) and the FF-STDP learning update port (U).
- U performs a read-modify-write: saturating signed add of a delta to the stored weight word.
- R has priority by default; a starvation limit guarantees U eventually gets the SRAM.

Parameters:
ADDR_WIDTH, 8, SRAM address width
DATA_WIDTH, 32, weight word width, two's complement signed
SRAM_DEPTH, 256, number of words; addresses >= SRAM_DEPTH are illegal (bench asserts, no RTL check)
DELTA_WIDTH, 8, signed update delta width, must be <= DATA_WIDTH
STARVE_LIMIT, 4, consecutive denied cycles of a pending U request before U overrides R; must be >= 1

Ports:
CK  in  1  clock; all state updates on rising edge
RSTN  in  1  reset, synchronous, active-low
rd_req  in  1  R request
rd_addr  in  ADDR_WIDTH  R address
rd_gnt  out  1  combinational; R request accepted this cycle
rd_valid  out  1  registered; 1-cycle pulse one cycle after rd_gnt
rd_data  out  DATA_WIDTH  = sram_q; meaningful only while rd_valid=1
upd_req  in  1  U request
upd_addr  in  ADDR_WIDTH  U address
upd_delta  in  DELTA_WIDTH  signed delta
upd_gnt  out  1  combinational; U request accepted; addr and delta captured this cycle
upd_done  out  1  registered; 1-cycle pulse after the write cycle
busy  out  1  1 while in state WR
sram_cs  out  1  to SRAM CS
sram_we  out  1  to SRAM WE
sram_a  out  ADDR_WIDTH  to SRAM A
sram_d  out  DATA_WIDTH  to SRAM D
sram_q  in  DATA_WIDTH  from SRAM Q

Behaviour:
- Handshake: requester holds req, addr and delta stable until its gnt cycle. The req→gnt path is combinational; deassert or change req after gnt.
- States: IDLE, WR.
- IDLE arbitration:
  - u_win = upd_req & (~rd_req | starve_cnt == STARVE_LIMIT).
  - u_win: upd_gnt=1, sram_cs=1, sram_we=0, sram_a=upd_addr. Capture upd_addr and upd_delta into registers; next state WR.
  - Else if rd_req: rd_gnt=1, sram_cs=1, sram_we=0, sram_a=rd_addr; rd_valid=1 next cycle; stay IDLE.
  - Else: sram_cs=0.
- Back-to-back R grants are allowed every cycle; throughput is 1 read per cycle.
- WR state:
  - Drive sram_cs=1, sram_we=1, sram_a=captured addr, sram_d=sat(sram_q + sext(delta)).
  - No grants; rd_gnt=0, upd_gnt=0.
  - Next state IDLE; upd_done=1 next cycle.
- U throughput: one RMW per 2 cycles minimum; IDLE always intervenes between two U grants.
- Saturation: sum computed at DATA_WIDTH+1 bits, clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. delta=0 still performs the write.
- starve_cnt:
  - Clears to 0 on upd_gnt.
  - Increments (saturating at STARVE_LIMIT) in cycles where upd_req=1 and upd_gnt=0, including WR cycles.
  - Holds when upd_req=0.
- Hazards: the R read in the cycle after WR returns the updated value. R is never granted during WR, so no stale reads occur.
- rd_data during the upd_done cycle is the pre-update value (SRAM old-data-on-write). It is not qualified by rd_valid.
- Reset while RSTN=0:
  - Outputs: sram_cs=0, sram_we=0, rd_gnt=0, upd_gnt=0, rd_valid=0, upd_done=0, busy=0. sram_a and sram_d are don't-care; tie them to 0.
  - State: state=IDLE, starve_cnt=0.
  - Reset during WR aborts the write; memory keeps the old word and no upd_done is produced.
- Latency: R is 1 cycle gnt→data. U is 2 cycles gnt→upd_done, with write committed at the end of the WR cycle.

Test Plan:
- Single read: preload [0x10]=0x0000_0123; rd_req with addr 0x10 → rd_gnt same cycle; next cycle rd_valid=1, rd_data=0x0000_0123.
- Single RMW: [0x20]=100, delta=-3 → upd_gnt; WR cycle sram_we=1, sram_d=97; upd_done next cycle; a subsequent read of 0x20 returns 97.
- Saturation:
  - [0x30]=0x7FFF_FFF0, delta=+127 → stored 0x7FFF_FFFF.
  - [0x31]=0x8000_0005, delta=-128 → stored 0x8000_0000.
- Starvation: rd_req held high every cycle while upd_req is high → upd_gnt in exactly the 5th cycle of U pending (4 denied cycles); rd_gnt=0 that cycle and during WR; R resumes after.
- Read-after-update: U grant on addr 0x40 ([0x40]=5, delta=+2), rd_req held for 0x40 → R granted the cycle after WR; rd_data=7.
- Reset mid-RMW: [0x50]=9, delta=+1; pull RSTN low in the WR cycle → no upd_done; after release, read of 0x50 returns 9 and all outputs are 0 during reset.
